// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled FSM, LSB-first shift.
// Optional parity check enabled with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Baud_Tick,
  input  logic                 Serial_In,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Framing_Err,
  output logic                 Parity_Err,
  output logic                 Rx_Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic sync1, sync2;
  logic [1:0] warm;
  logic line_hi;
  logic fell;
  logic start_go;

  // line_hi only trusts sync2 once the reset value has flushed out
  assign start_go = (state == IDLE) && Baud_Tick && !sync2
                    && (fell || line_hi);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      warm    <= 2'b00;
      line_hi <= 1'b0;
      fell    <= 1'b0;
    end else begin
      sync1   <= Serial_In;
      sync2   <= sync1;
      warm    <= {warm[0], 1'b1};
      line_hi <= warm[1] & sync2;
      fell    <= (state == IDLE) && !sync2
                 && (fell || line_hi) && !start_go;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_bad;
  logic par_err_q;
  assign Parity_Err = par_err_q;
`else
  logic unused_odd;
  assign unused_odd = (PARITY_ODD != 0);
  assign Parity_Err = 1'b0;
`endif

  assign Rx_Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      Rx_Data     <= '0;
      Data_Rdy    <= 1'b0;
      Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      Data_Rdy    <= 1'b0;
      Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (Baud_Tick) begin
        unique case (state)
          IDLE: begin
            if (start_go) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == CNT_MID) begin
              cnt     <= '0;
              bit_cnt <= '0;
              state   <= sync2 ? IDLE : DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == CNT_MAX) begin
              cnt   <= '0;
              shreg <= {sync2, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_MAX) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == CNT_MAX) begin
              cnt     <= '0;
              par_bad <= sync2 ^ (^shreg) ^ ODD;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (cnt == CNT_MAX) begin
              cnt   <= '0;
              state <= IDLE;
              if (sync2) begin
                Rx_Data  <= shreg;
                Data_Rdy <= 1'b1;
`ifdef UART_RX_PARITY_EN
                par_err_q <= par_bad;
`endif
              end else begin
                Framing_Err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
